pc_redirect_ctrl: RTL and testbench



---
 rtl/pc_redirect_ctrl.sv | 158 +++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Purpose: EX-to-fetch control-hazard sequencer; issues PC redirects and wrong-path flush strobes.
// Latency: an event sampled at edge T raises redir_valid/flushes/ex_hold from T+1; all outputs registered.
// Backpressure: redir_valid/redir_pc held stable and ex_hold asserted until redir_ready; optional REDIRECT_PERF_EN adds perf counters.
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_instr,
  input  logic        ex_pcsel,
  input  logic [31:0] ex_target,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [31:0] redir_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        ex_hold,
  output logic        misalign_err,
  output logic [31:0] perf_branch_taken,
  output logic [31:0] perf_jump
);

  typedef enum logic [1:0] {S_RUN, S_REQ, S_SQUASH} state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] CNT_INIT  = 3'(FLUSH_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        r_redir_valid;
  logic [31:0] r_redir_pc;
  logic        r_flush;
  logic        r_hold;
  logic        r_misalign;
  logic        r_is_branch;

  logic [6:0]  w_opcode;
  logic        w_is_branch;
  logic        w_is_jump;
  logic [31:0] w_tgt;
  logic        w_cand;
  logic        w_misalign;
  logic        w_event;
  logic        w_accept;
  logic        w_valid_nxt;
  logic        w_flush_nxt;
  logic        w_hold_nxt;
  logic        w_unused;

  // Decode the EX instruction; only BRANCH/JAL/JALR can redirect, anything else is ignored.
  assign w_opcode    = ex_instr[6:0];
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_is_jump   = (w_opcode == OP_JAL) || (w_opcode == OP_JALR);
  assign w_tgt       = (w_opcode == OP_JALR) ? {ex_target[31:1], 1'b0} : ex_target;
  assign w_cand      = (r_state == S_RUN) && ex_valid && ex_pcsel && (w_is_branch || w_is_jump);
  assign w_misalign  = w_cand && (w_tgt[1:0] != 2'b00);
  assign w_event     = w_cand && !w_misalign;
  assign w_accept    = (r_state == S_REQ) && redir_ready;
  assign w_unused    = &{1'b0, ex_instr[31:7]};

  // Next-state logic: RUN -> REQ on a good event, REQ waits for fetch, SQUASH counts the wrong-path window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (w_event) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (redir_ready) begin
          if (FLUSH_CYCLES == 1) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_SQUASH;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_SQUASH: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (w_cnt_nxt == 3'd0) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Output decode of the next state, so every output comes straight from a flop.
  always_comb begin
    w_valid_nxt = (w_state_nxt == S_REQ);
    w_hold_nxt  = (w_state_nxt == S_REQ);
    w_flush_nxt = (w_state_nxt != S_RUN);
  end

  // State and output registers; redir_pc/kind latched only on an event, so they hold through REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_cnt         <= 3'd0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= 32'd0;
      r_flush       <= 1'b0;
      r_hold        <= 1'b0;
      r_misalign    <= 1'b0;
      r_is_branch   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_redir_valid <= w_valid_nxt;
      r_flush       <= w_flush_nxt;
      r_hold        <= w_hold_nxt;
      r_misalign    <= w_misalign;
      if (w_event) begin
        r_redir_pc  <= w_tgt;
        r_is_branch <= w_is_branch;
      end
    end
  end

  assign redir_valid  = r_redir_valid;
  assign redir_pc     = r_redir_pc;
  assign flush_if_id  = r_flush;
  assign flush_id_ex  = r_flush;
  assign ex_hold      = r_hold;
  assign misalign_err = r_misalign;

`ifdef REDIRECT_PERF_EN
  logic [31:0] r_perf_bt;
  logic [31:0] r_perf_jmp;

  // Saturating counters bumped on the handshake edge, classified by the latched instruction kind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_bt  <= 32'd0;
      r_perf_jmp <= 32'd0;
    end else if (w_accept) begin
      if (r_is_branch) begin
        if (r_perf_bt != 32'hFFFF_FFFF) r_perf_bt <= r_perf_bt + 32'd1;
      end else begin
        if (r_perf_jmp != 32'hFFFF_FFFF) r_perf_jmp <= r_perf_jmp + 32'd1;
      end
    end
  end

  assign perf_branch_taken = r_perf_bt;
  assign perf_jump         = r_perf_jmp;
`else
  logic w_unused_perf;
  assign w_unused_perf     = &{1'b0, w_accept, r_is_branch};
  assign perf_branch_taken = 32'd0;
  assign perf_jump         = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: expected output bundles queued per step and compared after the edge.
module tb_pc_redirect_ctrl;

`ifdef REDIRECT_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;
  localparam logic [31:0] ADD  = 32'h0000_0033;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        fi;
    logic        fe;
    logic        h;
    logic        m;
    logic [31:0] pb;
    logic [31:0] pj;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_instr;
  logic        ex_pcsel;
  logic [31:0] ex_target;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        ex_hold;
  logic        misalign_err;
  logic [31:0] perf_branch_taken;
  logic [31:0] perf_jump;

  obs_t        exp_q[$];
  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_pb = 32'd0;
  logic [31:0] exp_pj = 32'd0;

  pc_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pcsel(ex_pcsel), .ex_target(ex_target),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .ex_hold(ex_hold),
    .misalign_err(misalign_err), .perf_branch_taken(perf_branch_taken), .perf_jump(perf_jump)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the outputs required after the next edge, then check them.
  task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic sel,
                      input logic [31:0] tgt, input logic rdy,
                      input logic e_v, input logic [31:0] e_pc, input logic e_fl,
                      input logic e_h, input logic e_m);
    obs_t e;
    obs_t a;
    ex_valid    = v;
    ex_instr    = ins;
    ex_pcsel    = sel;
    ex_target   = tgt;
    redir_ready = rdy;
    e = '{v: e_v, pc: e_pc, fi: e_fl, fe: e_fl, h: e_h, m: e_m,
          pb: (PERF ? exp_pb : 32'd0), pj: (PERF ? exp_pj : 32'd0)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    a = '{v: redir_valid, pc: redir_pc, fi: flush_if_id, fe: flush_id_ex, h: ex_hold,
          m: misalign_err, pb: perf_branch_taken, pj: perf_jump};
    e = exp_q.pop_front();
    checks++;
    assert (a === e) else begin
      fails++;
      $error("FAIL %s observed=%h required=%h", tag, a, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_instr = NOP; ex_pcsel = 1'b0; ex_target = 32'd0; redir_ready = 1'b0;
    step("reset0", 0, NOP, 0, 0, 0,  0, 32'h0, 0, 0, 0);
    step("reset1", 1, BEQ, 1, 32'h100, 1,  0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    step("idle", 0, NOP, 0, 0, 1,  0, 32'h0, 0, 0, 0);

    // taken BEQ, fetch ready immediately
    step("beq_req",     1, BEQ, 1, 32'h100, 1,  1, 32'h100, 1, 1, 0);
    exp_pb = 32'd1;
    step("beq_squash",  0, NOP, 0, 0, 1,        0, 32'h100, 1, 0, 0);
    step("beq_run",     0, NOP, 0, 0, 1,        0, 32'h100, 0, 0, 0);

    // JALR misaligned after bit-0 clear, then aligned with fetch stalling 3 cycles
    step("jalr_mis",    1, JALR, 1, 32'h2003, 0, 0, 32'h100, 0, 0, 1);
    step("jalr_mis_end",0, NOP, 0, 0, 0,         0, 32'h100, 0, 0, 0);
    step("jalr_req",    1, JALR, 1, 32'h2001, 0, 1, 32'h2000, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      step("jalr_stall",1, BEQ, 1, 32'h300, 0,   1, 32'h2000, 1, 1, 0);
    exp_pj = 32'd1;
    step("jalr_squash", 0, NOP, 0, 0, 1,         0, 32'h2000, 1, 0, 0);
    step("jalr_run",    0, NOP, 0, 0, 0,         0, 32'h2000, 0, 0, 0);

    // taken branch then wrong-path JAL requests
    step("wp_req",      1, BEQ, 1, 32'h200, 1,   1, 32'h200, 1, 1, 0);
    exp_pb = 32'd2;
    step("wp_jal1",     1, JAL, 1, 32'h500, 1,   0, 32'h200, 1, 0, 0);
    step("wp_jal2",     1, JAL, 1, 32'h500, 1,   0, 32'h200, 0, 0, 0);
    ex_valid = 1'b0;
    step("wp_idle",     0, NOP, 0, 0, 1,         0, 32'h200, 0, 0, 0);

    // reset during SQUASH, then a fresh JAL
    step("rs_req",      1, BEQ, 1, 32'h80, 1,    1, 32'h80, 1, 1, 0);
    exp_pb = 32'd3;
    step("rs_squash",   0, NOP, 0, 0, 1,         0, 32'h80, 1, 0, 0);
    rst = 1'b1;
    exp_pb = 32'd0;
    exp_pj = 32'd0;
    step("rs_reset",    1, JAL, 1, 32'h44, 1,    0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    step("rs_jal_req",  1, JAL, 1, 32'h40, 1,    1, 32'h40, 1, 1, 0);
    exp_pj = 32'd1;
    step("rs_jal_sq",   0, NOP, 0, 0, 1,         0, 32'h40, 1, 0, 0);
    step("rs_jal_run",  0, NOP, 0, 0, 1,         0, 32'h40, 0, 0, 0);

    // non-events
    step("not_taken",   1, BEQ, 0, 32'h900, 1,   0, 32'h40, 0, 0, 0);
    step("bubble",      0, JAL, 1, 32'h904, 1,   0, 32'h40, 0, 0, 0);
    step("alu_pcsel",   1, ADD, 1, 32'h908, 1,   0, 32'h40, 0, 0, 0);

    // back-to-back JAL requests with fetch always ready: spacing 1+FLUSH_CYCLES
    step("b2b_req1",    1, JAL, 1, 32'h1000, 1,  1, 32'h1000, 1, 1, 0);
    exp_pj = 32'd2;
    step("b2b_sq1",     1, JAL, 1, 32'h1004, 1,  0, 32'h1000, 1, 0, 0);
    step("b2b_run1",    1, JAL, 1, 32'h1008, 1,  0, 32'h1000, 0, 0, 0);
    step("b2b_req2",    1, JAL, 1, 32'h100C, 1,  1, 32'h100C, 1, 1, 0);
    exp_pj = 32'd3;
    step("b2b_sq2",     1, JAL, 1, 32'h1010, 1,  0, 32'h100C, 1, 0, 0);
    step("b2b_run2",    0, NOP, 0, 0, 1,         0, 32'h100C, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
